iddr_deser: RTL and testbench
=============================

IDDR_DESER -- requirements
Module: iddr_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of input lanes (1..32).
REQ-002 SHALL have parameter RATIO, default 4, bits per lane per output word (2, 4 or 8).
REQ-003 SHALL have parameter DDR_CLK_EDGE, default "SAME_EDGE_PIPELINED", Q1/Q2 alignment mode ("OPPOSITE_EDGE", "SAME_EDGE" or "SAME_EDGE_PIPELINED").
REQ-004 SHALL have parameter IS_C_INVERTED, default 1'b0; when 1, all edge roles of C swap.
REQ-005 SHALL have port C, input, 1, the one clock; both edges sample D.
REQ-006 SHALL have port RN, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port CE, input, 1, capture enable, sampled on each C edge.
REQ-008 SHALL have port D, input, WIDTH, DDR serial data, one bit per lane.
REQ-009 SHALL have port BITSLIP, input, 1, word-boundary slip request, sampled on rising C.
REQ-010 SHALL have ports Q1 and Q2, output, WIDTH, per-cycle rising/falling sample pair.
REQ-011 SHALL have port Q, output, WIDTH*RATIO; lane i occupies Q[i*RATIO +: RATIO], MSB is the earliest-received bit.
REQ-012 SHALL have port Q_VALID, output, 1, one-cycle strobe marking a new Q word.

Function
REQ-013 SHALL capture r_k on rising edge k and f_k on the following falling edge, per lane, only when CE=1 at that edge.
REQ-014 OPPOSITE_EDGE: Q1 SHALL update to r_k at rising edge k; Q2 SHALL update to f_k at the following falling edge.
REQ-015 SAME_EDGE: at rising edge k, Q1 SHALL update to r_k and Q2 to f_(k-1).
REQ-016 SAME_EDGE_PIPELINED: at rising edge k+1, Q1 SHALL update to r_k and Q2 to f_k.
REQ-017 Independent of mode, at rising edge k+1 with CE=1, each lane shift register SHALL shift in the pair (r_k, f_k), r_k older.
REQ-018 SHALL keep a pair counter 0..RATIO/2-1 that increments on each shift and wraps to 0.
REQ-019 On a shift with counter = RATIO/2-1, Q SHALL load all RATIO bits of the completed frame at that edge; Q_VALID SHALL be 1 for that one cycle only.
REQ-020 With CE=0 at a rising edge: no shift, counter holds, Q1/Q2/Q hold, Q_VALID=0.
REQ-021 An accepted BITSLIP SHALL hold the counter for that shift, so the pair still shifts in and the word boundary moves 2 bit positions later.
REQ-022 BITSLIP in the cycle immediately after an accepted slip SHALL be ignored; BITSLIP with CE=0 SHALL be ignored.
REQ-023 BITSLIP coincident with counter = RATIO/2-1 SHALL suppress that Q load and its Q_VALID.

Reset
REQ-024 RN=0 SHALL asynchronously clear r/f samples, Q1, Q2, Q, shift registers, counter, slip guard and Q_VALID to 0.
REQ-025 After RN rises, the first Q_VALID SHALL occur on the RATIO/2-th shift (CE=1, no slips).
REQ-026 Reset mid-frame SHALL discard the partial frame; no Q_VALID for it.

Configuration
REQ-027 With macro IDDR_DESER_BITSLIP_EN defined, BITSLIP SHALL behave per REQ-021..023.
REQ-028 Without IDDR_DESER_BITSLIP_EN, BITSLIP SHALL be ignored, the slip logic SHALL be absent and the port SHALL be retained.

Verification
REQ-029 WIDTH=1, RATIO=4, CE=1, D stream 1,0,1,1 repeating from reset -> Q=4'b1011 with Q_VALID every 2nd rising edge, first after 2 shifts.
REQ-030 Each DDR_CLK_EDGE value, D=1 on rising and 0 on falling -> Q1=1, Q2=0 at the edge times of REQ-014..016.
REQ-031 CE=0 for 3 cycles mid-frame -> Q, Q1, Q2 and counter frozen, no Q_VALID, frame resumes intact.
REQ-032 RATIO=8, stream 8'hA5 repeating, one BITSLIP pulse -> next word delayed one cycle, then Q=8'h96 steadily; back-to-back BITSLIP -> second ignored.
REQ-033 RN low for 1 ns mid-frame -> all outputs 0 immediately; next Q_VALID on the 2nd shift after release (RATIO=4).
REQ-034 Build without IDDR_DESER_BITSLIP_EN, repeat REQ-032 -> Q stays 8'hA5, word timing unchanged.

Source files
------------

// File: rtl/iddr_deser.sv
`timescale 1ns/1ps
// iddr_deser: DDR input capture with per-lane 1:RATIO deserialisation.
//
// Each lane samples D on both edges of C. Each rising/falling sample pair is
// shifted into a per-lane shift register, and the register is unloaded into Q
// once every RATIO/2 pairs. Q1/Q2 present the raw sample pair, aligned
// according to DDR_CLK_EDGE.
//
// Parameters
//   WIDTH         number of lanes (1..32)
//   RATIO         bits per lane per output word (2, 4 or 8)
//   DDR_CLK_EDGE  "OPPOSITE_EDGE" | "SAME_EDGE" | "SAME_EDGE_PIPELINED"
//   IS_C_INVERTED swap the rising/falling roles of C
//
// Ports
//   C        clock; both edges sample D
//   RN       asynchronous active-low reset
//   CE       capture enable, sampled on every C edge
//   D        serial data, one bit per lane
//   BITSLIP  word-boundary slip request, sampled on the rising edge
//   Q1, Q2   rising/falling sample pair
//   Q        deserialised word; lane i at Q[i*RATIO +: RATIO], MSB oldest
//   Q_VALID  one-cycle strobe marking a new Q word
//
// Optional feature: define IDDR_DESER_BITSLIP_EN to build the slip logic.
// Without it BITSLIP is accepted on the port but has no effect.
module iddr_deser #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned RATIO         = 4,
  parameter string       DDR_CLK_EDGE  = "SAME_EDGE_PIPELINED",
  parameter bit          IS_C_INVERTED = 1'b0
) (
  input  logic                   C,
  input  logic                   RN,
  input  logic                   CE,
  input  logic [WIDTH-1:0]       D,
  input  logic                   BITSLIP,
  output logic [WIDTH-1:0]       Q1,
  output logic [WIDTH-1:0]       Q2,
  output logic [WIDTH*RATIO-1:0] Q,
  output logic                   Q_VALID
);

  localparam int unsigned QW    = WIDTH * RATIO;
  localparam int unsigned PAIRS = RATIO / 2;
  localparam int unsigned CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAIRS - 1);

  localparam bit MODE_OPP  = (DDR_CLK_EDGE == "OPPOSITE_EDGE");
  localparam bit MODE_SAME = (DDR_CLK_EDGE == "SAME_EDGE");
  // Unrecognised mode strings fall back to the pipelined alignment.
  localparam bit MODE_PIPE = !MODE_OPP && !MODE_SAME;

  // Effective clock: its rising edge is the "rising" role of C.
  logic clk;
  logic rst_n;
  assign clk   = C ^ IS_C_INVERTED;
  assign rst_n = RN;

  logic [WIDTH-1:0] r_q;        // latest rising-edge sample
  logic [WIDTH-1:0] f_q;        // latest falling-edge sample
  logic             primed;     // a rising sample exists since reset
  logic [CNT_W-1:0] cnt;        // pairs already in the current frame
  logic [QW-1:0]    sr;         // per-lane partial frames
  logic [QW-1:0]    sr_next_c;
  logic [QW-1:0]    q_r;
  logic             q_valid_r;
  logic [RATIO-1:0] lane_c;
  logic             shift_c;
  logic             slip_c;
  logic             load_c;

  // Falling-edge capture.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= '0;
    end else if (CE) begin
      f_q <= D;
    end
  end

  // A pair is complete only once a rising sample has been taken, so the
  // first enabled rising edge after reset captures but does not shift.
  assign shift_c = CE & primed;

`ifdef IDDR_DESER_BITSLIP_EN
  logic slip_guard;

  // A slip is honoured only on a real shift and never on two edges in a row.
  assign slip_c = shift_c & BITSLIP & ~slip_guard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_guard <= 1'b0;
    end else begin
      slip_guard <= slip_c;
    end
  end
`else
  logic unused_bitslip;
  assign unused_bitslip = BITSLIP;
  assign slip_c         = 1'b0;
`endif

  // A slipped shift keeps the counter still, so the frame it lands in is one
  // pair longer and the boundary moves two bits later.
  assign load_c = shift_c & ~slip_c & (cnt == CNT_LAST);

  // Next shift-register image: older pair moves up, (r, f) enters at the LSBs.
  always_comb begin
    sr_next_c = sr;
    lane_c    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      lane_c = sr[i*RATIO +: RATIO];
      lane_c = (lane_c << 2) | RATIO'({r_q[i], f_q[i]});
      sr_next_c[i*RATIO +: RATIO] = lane_c;
    end
  end

  // Rising-edge capture, shift, framing and word output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      primed    <= 1'b0;
      cnt       <= '0;
      sr        <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      q_valid_r <= load_c;
      if (CE) begin
        r_q    <= D;
        primed <= 1'b1;
      end
      if (shift_c) begin
        sr <= sr_next_c;
      end
      if (shift_c && !slip_c) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end
      if (load_c) begin
        q_r <= sr_next_c;
      end
    end
  end

  assign Q       = q_r;
  assign Q_VALID = q_valid_r;

  // Q1: the rising sample is already a rising-edge register unless the
  // pipelined mode wants it one edge later.
  if (MODE_PIPE) begin : g_q1_pipe
    logic [WIDTH-1:0] q1_r;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q1_r <= '0;
      end else if (CE) begin
        q1_r <= r_q;
      end
    end
    assign Q1 = q1_r;
  end else begin : g_q1_direct
    assign Q1 = r_q;
  end

  // Q2: opposite-edge mode exposes the falling register itself; the other
  // modes retime the last falling sample onto the rising edge.
  if (MODE_OPP) begin : g_q2_fall
    assign Q2 = f_q;
  end else begin : g_q2_rise
    logic [WIDTH-1:0] q2_r;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q2_r <= '0;
      end else if (CE) begin
        q2_r <= f_q;
      end
    end
    assign Q2 = q2_r;
  end

endmodule

// File: tb/tb_iddr_deser.sv
`timescale 1ns/1ps
// tb_iddr_deser: six iddr_deser instances sharing one stimulus stream,
// compared against a stream-level reference model.
//   u0 RATIO=4 pipelined, u1 RATIO=4 opposite-edge, u2 RATIO=4 same-edge,
//   u3 RATIO=8 pipelined, u4 RATIO=4 pipelined on inverted C, u5 RATIO=2.
module tb_iddr_deser;

  localparam int NDUT = 6;
  localparam int NL   = 4;
  localparam int RAT  [NDUT] = '{4, 4, 4, 8, 4, 2};
  localparam int MODE [NDUT] = '{0, 1, 2, 0, 0, 0};  // 0 pipe, 1 opposite, 2 same

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          c_inv;
  logic          rn;
  logic          ce;
  logic [NL-1:0] d;
  logic          bitslip;
  assign c_inv = ~clk;

  logic [NL-1:0] q1a [NDUT];
  logic [NL-1:0] q2a [NDUT];
  logic          qva [NDUT];
  logic [15:0]   q_d0, q_d1, q_d2, q_d4;
  logic [31:0]   q_d3;
  logic [7:0]    q_d5;
  logic [31:0]   qa  [NDUT];

  always_comb begin
    qa[0] = 32'(q_d0);
    qa[1] = 32'(q_d1);
    qa[2] = 32'(q_d2);
    qa[3] = q_d3;
    qa[4] = 32'(q_d4);
    qa[5] = 32'(q_d5);
  end

  iddr_deser #(.WIDTH(NL), .RATIO(4), .DDR_CLK_EDGE("SAME_EDGE_PIPELINED"), .IS_C_INVERTED(1'b0)) u0 (
    .C(clk), .RN(rn), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q1(q1a[0]), .Q2(q2a[0]), .Q(q_d0), .Q_VALID(qva[0]));
  iddr_deser #(.WIDTH(NL), .RATIO(4), .DDR_CLK_EDGE("OPPOSITE_EDGE"), .IS_C_INVERTED(1'b0)) u1 (
    .C(clk), .RN(rn), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q1(q1a[1]), .Q2(q2a[1]), .Q(q_d1), .Q_VALID(qva[1]));
  iddr_deser #(.WIDTH(NL), .RATIO(4), .DDR_CLK_EDGE("SAME_EDGE"), .IS_C_INVERTED(1'b0)) u2 (
    .C(clk), .RN(rn), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q1(q1a[2]), .Q2(q2a[2]), .Q(q_d2), .Q_VALID(qva[2]));
  iddr_deser #(.WIDTH(NL), .RATIO(8), .DDR_CLK_EDGE("SAME_EDGE_PIPELINED"), .IS_C_INVERTED(1'b0)) u3 (
    .C(clk), .RN(rn), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q1(q1a[3]), .Q2(q2a[3]), .Q(q_d3), .Q_VALID(qva[3]));
  iddr_deser #(.WIDTH(NL), .RATIO(4), .DDR_CLK_EDGE("SAME_EDGE_PIPELINED"), .IS_C_INVERTED(1'b1)) u4 (
    .C(c_inv), .RN(rn), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q1(q1a[4]), .Q2(q2a[4]), .Q(q_d4), .Q_VALID(qva[4]));
  iddr_deser #(.WIDTH(NL), .RATIO(2), .DDR_CLK_EDGE("SAME_EDGE_PIPELINED"), .IS_C_INVERTED(1'b0)) u5 (
    .C(clk), .RN(rn), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q1(q1a[5]), .Q2(q2a[5]), .Q(q_d5), .Q_VALID(qva[5]));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a history of received bits per lane; a word is the
  // newest RATIO bits whenever RATIO/2 unslipped pairs have arrived.
  bit            hist [NL][$];
  bit            primed;
  bit            guard;
  logic [NL-1:0] pend_r, pend_f;
  int            fcnt [NDUT];
  logic [31:0]   eq   [NDUT];
  bit            eqv  [NDUT];
  logic [NL-1:0] eq1  [3];
  logic [NL-1:0] eq2  [3];

  task automatic model_reset();
    for (int l = 0; l < NL; l++) hist[l].delete();
    primed = 0; guard = 0; pend_r = '0; pend_f = '0;
    for (int u = 0; u < NDUT; u++) begin
      fcnt[u] = 0; eq[u] = '0; eqv[u] = 0;
    end
    for (int m = 0; m < 3; m++) begin
      eq1[m] = '0; eq2[m] = '0;
    end
  endtask

  function automatic logic [31:0] frame(input int r);
    logic [31:0] w = '0;
    for (int l = 0; l < NL; l++)
      for (int b = 0; b < r; b++)
        w[l*r + r-1-b] = hist[l][hist[l].size() - r + b];
    return w;
  endfunction

  task automatic model_rise(input bit c, input bit bs, input logic [NL-1:0] dv);
    bit sh, acc;
    sh  = c && primed;
    acc = 0;
`ifdef IDDR_DESER_BITSLIP_EN
    acc = sh && bs && !guard;
`endif
    guard = acc;
    if (sh) begin
      for (int l = 0; l < NL; l++) begin
        hist[l].push_back(pend_r[l]);
        hist[l].push_back(pend_f[l]);
        while (hist[l].size() > 16) void'(hist[l].pop_front());
      end
    end
    for (int u = 0; u < NDUT; u++) begin
      eqv[u] = 0;
      if (sh && !acc) begin
        fcnt[u]++;
        if (fcnt[u] == RAT[u] / 2) begin
          fcnt[u] = 0;
          eq[u]   = frame(RAT[u]);
          eqv[u]  = 1;
        end
      end
    end
    if (c) begin
      eq1[0] = pend_r; eq2[0] = pend_f;   // pipelined: previous pair
      eq1[1] = dv;                        // opposite: rising sample now
      eq1[2] = dv;     eq2[2] = pend_f;   // same-edge: this r, previous f
      pend_r = dv;
      primed = 1;
    end
  endtask

  task automatic model_fall(input bit c, input logic [NL-1:0] dv);
    if (c) begin
      pend_f = dv;
      eq2[1] = dv;
    end
  endtask

  task automatic check_outputs(input string ph);
    for (int u = 0; u < NDUT; u++) begin
      check($sformatf("%s.u%0d.q", ph, u), qa[u], eq[u]);
      check($sformatf("%s.u%0d.qv", ph, u), 32'(qva[u]), 32'(eqv[u]));
      check($sformatf("%s.u%0d.q1", ph, u), 32'(q1a[u]), 32'(eq1[MODE[u]]));
      check($sformatf("%s.u%0d.q2", ph, u), 32'(q2a[u]), 32'(eq2[MODE[u]]));
    end
  endtask

  task automatic check_zero(input string ph);
    for (int u = 0; u < NDUT; u++) begin
      check($sformatf("%s.u%0d.q", ph, u), qa[u], 32'h0);
      check($sformatf("%s.u%0d.qv", ph, u), 32'(qva[u]), 32'h0);
      check($sformatf("%s.u%0d.q1", ph, u), 32'(q1a[u]), 32'h0);
      check($sformatf("%s.u%0d.q2", ph, u), 32'(q2a[u]), 32'h0);
    end
  endtask

  // One clock cycle: r value before the rising edge, f value before the falling edge.
  task automatic cycle(input bit c, input bit bs, input logic [NL-1:0] dr, input logic [NL-1:0] df);
    ce = c; bitslip = bs; d = dr;
    @(posedge clk);
    model_rise(c, bs, dr);
    #2;
    check_outputs("rise");
    d = df;
    @(negedge clk);
    model_fall(c, df);
    #2;
    check_outputs("fall");
  endtask

  task automatic pulse_reset(input string ph);
    rn = 1'b0;
    #0.5;
    check_zero(ph);
    model_reset();
    #0.5;
    rn = 1'b1;
  endtask

  logic [NL-1:0] rv, fv;
  logic [7:0]    pat;
  logic [31:0]   exp_slip1, exp_slip2;
  int            k;

  initial begin
    rn = 1'b0; ce = 1'b0; d = '0; bitslip = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    @(negedge clk);
    #2;
    rn = 1'b1;

    // Lane 0 carries 1,0,1,1 repeating; the other lanes are random.
    for (int n = 0; n < 12; n++) begin
      rv = NL'($urandom); fv = NL'($urandom);
      rv[0] = 1'b1;
      fv[0] = n[0];
      cycle(1'b1, 1'b0, rv, fv);
    end
    check("pat1011", 32'(q_d0[3:0]), 32'hB);

    // Random data, sporadic CE gaps and one forced three-cycle freeze.
    for (int n = 0; n < 150; n++) begin
      bit c;
      c = ($urandom_range(0, 3) != 0);
      if (n >= 40 && n < 43) c = 1'b0;
      cycle(c, 1'b0, NL'($urandom), NL'($urandom));
    end

    // Make sure the reset below lands in the middle of a frame.
    k = 0;
    while (fcnt[0] == 0 && k < 8) begin
      cycle(1'b1, 1'b0, NL'($urandom), NL'($urandom));
      k++;
    end
    pulse_reset("midreset");

    // 8'hA5 on every lane from a fresh boundary, one slip, then two in a row.
    pat = 8'hA5;
`ifdef IDDR_DESER_BITSLIP_EN
    exp_slip1 = 32'h96;
    exp_slip2 = 32'h5A;
`else
    exp_slip1 = 32'hA5;
    exp_slip2 = 32'hA5;
`endif
    for (int n = 0; n < 32; n++) begin
      bit bs;
      bs = (n == 10) || (n == 20) || (n == 21);
      rv = {NL{pat[7 - 2*(n % 4)]}};
      fv = {NL{pat[6 - 2*(n % 4)]}};
      cycle(1'b1, bs, rv, fv);
      if (n == 19) check("a5_slip1", 32'(q_d3[7:0]), exp_slip1);
    end
    check("a5_slip2", 32'(q_d3[7:0]), exp_slip2);

    // Random data, CE and slip requests together.
    for (int n = 0; n < 200; n++) begin
      cycle($urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
            NL'($urandom), NL'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
